// File: rtl/alu_issue_unit.sv
// RV32I OP / OP-IMM issue front end: decodes one instruction at a time, drives the
// ALU operand interface, then writes the sampled ALU result back to a 32x32 register file.
module alu_issue_unit #(
    parameter int unsigned RESULT_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        alu_en,
    output logic        alu_r,
    output logic        alu_i,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [31:0] alu_imm,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEC   = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [2:0] WAIT_LOAD  = 3'(RESULT_WAIT);

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        instr_ready_q, instr_ready_d;
    logic        alu_en_q, alu_en_d;
    logic        alu_r_q, alu_r_d;
    logic        alu_i_q, alu_i_d;
    logic [31:0] alu_op1_q, alu_op1_d;
    logic [31:0] alu_op2_q, alu_op2_d;
    logic [31:0] alu_imm_q, alu_imm_d;
    logic [3:0]  alu_opcode_q, alu_opcode_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        illegal_q, illegal_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    // Only the OP group and OP-IMM group are accepted; shift-immediates constrain funct7.
    function automatic logic is_legal(input logic [31:0] ins);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        if (ins[6:0] == OPC_OP) begin
            return (f7 == F7_ZERO) ||
                   ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        end else if (ins[6:0] == OPC_OP_IMM) begin
            case (f3)
                3'b001:  return (f7 == F7_ZERO);
                3'b101:  return (f7 == F7_ZERO) || (f7 == F7_ALT);
                default: return 1'b1;
            endcase
        end else begin
            return 1'b0;
        end
    endfunction

    // Next-state, datapath and register-file update
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        cnt_d        = cnt_q;
        alu_en_d     = 1'b0;
        alu_r_d      = alu_r_q;
        alu_i_d      = alu_i_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_imm_d    = alu_imm_q;
        alu_opcode_d = alu_opcode_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        illegal_d    = 1'b0;
        rf_d         = rf_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DEC: begin
                if (is_legal(instr_q)) begin
                    alu_op1_d = rf_q[instr_q[19:15]];
                    if (instr_q[6:0] == OPC_OP) begin
                        alu_r_d      = 1'b1;
                        alu_i_d      = 1'b0;
                        alu_op2_d    = rf_q[instr_q[24:20]];
                        alu_imm_d    = 32'd0;
                        alu_opcode_d = {instr_q[14:12], instr_q[30]};
                    end else begin
                        alu_r_d      = 1'b0;
                        alu_i_d      = 1'b1;
                        alu_op2_d    = 32'd0;
                        alu_imm_d    = {{20{instr_q[31]}}, instr_q[31:20]};
                        // ADDI must never turn into a subtract; only SRLI/SRAI use bit 30
                        if (instr_q[14:12] == 3'b101) begin
                            alu_opcode_d = {instr_q[14:12], instr_q[30]};
                        end else begin
                            alu_opcode_d = {instr_q[14:12], 1'b0};
                        end
                    end
                    state_d = S_ISSUE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_ISSUE: begin
                alu_en_d = 1'b1;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d      = 3'd0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = instr_q[11:7];
                    wb_data_d  = alu_result;
                    if (instr_q[11:7] != 5'd0) begin
                        rf_d[instr_q[11:7]] = alu_result;
                    end else begin
                        rf_d[0] = 32'd0;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        instr_ready_d = (state_d == S_IDLE);
    end

    // State, output and register-file flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_q       <= 32'd0;
            cnt_q         <= 3'd0;
            instr_ready_q <= 1'b1;
            alu_en_q      <= 1'b0;
            alu_r_q       <= 1'b0;
            alu_i_q       <= 1'b0;
            alu_op1_q     <= 32'd0;
            alu_op2_q     <= 32'd0;
            alu_imm_q     <= 32'd0;
            alu_opcode_q  <= 4'd0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= 32'd0;
            illegal_q     <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            cnt_q         <= cnt_d;
            instr_ready_q <= instr_ready_d;
            alu_en_q      <= alu_en_d;
            alu_r_q       <= alu_r_d;
            alu_i_q       <= alu_i_d;
            alu_op1_q     <= alu_op1_d;
            alu_op2_q     <= alu_op2_d;
            alu_imm_q     <= alu_imm_d;
            alu_opcode_q  <= alu_opcode_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            illegal_q     <= illegal_d;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_en      = alu_en_q;
    assign alu_r       = alu_r_q;
    assign alu_i       = alu_i_q;
    assign alu_op1     = alu_op1_q;
    assign alu_op2     = alu_op2_q;
    assign alu_imm     = alu_imm_q;
    assign alu_opcode  = alu_opcode_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign illegal     = illegal_q;
    assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit; the bench also plays the ALU, computing its
// result on the rising edge of alu_en.
module tb_alu_issue_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        alu_en;
    logic        alu_r;
    logic        alu_i;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_imm;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int compared   = 0;
    int mismatched = 0;

    alu_issue_unit #(.RESULT_WAIT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_en      (alu_en),
        .alu_r       (alu_r),
        .alu_i       (alu_i),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_imm     (alu_imm),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: acts on the rising edge of alu_en.
    always @(posedge alu_en) begin
        logic [31:0] b;
        b = alu_r ? alu_op2 : alu_imm;
        case (alu_opcode)
            4'b0000: alu_result = alu_op1 + b;
            4'b0001: alu_result = alu_op1 - b;
            4'b0010: alu_result = alu_op1 << b[4:0];
            4'b0100: alu_result = ($signed(alu_op1) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0110: alu_result = (alu_op1 < b) ? 32'd1 : 32'd0;
            4'b1000: alu_result = alu_op1 ^ b;
            4'b1010: alu_result = alu_op1 >> b[4:0];
            4'b1011: alu_result = $unsigned($signed(alu_op1) >>> b[4:0]);
            4'b1100: alu_result = alu_op1 | b;
            4'b1110: alu_result = alu_op1 & b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    // Present one instruction for one cycle; accept happens at the next rising edge.
    task automatic send(input logic [31:0] w);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Count edges until wb_valid is seen (bounded) and how many of them had alu_en high.
    task automatic run_to_wb(output int n, output int en_cnt);
        n      = 0;
        en_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (alu_en) en_cnt++;
        end while (!wb_valid && n < 20);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        dbg_addr    = 5'd0;
        alu_result  = 32'd0;
        #12;
        compared++;
        if ({alu_en, alu_r, alu_i, wb_valid, illegal} !== 5'b00000) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 00000", {alu_en, alu_r, alu_i, wb_valid, illegal});
        end
        compared++;
        if ({alu_op1, alu_op2, alu_imm, alu_opcode, wb_rd, wb_data} !== 137'd0) begin
            mismatched++;
            $display("FAIL reset_data: got op1=%h op2=%h imm=%h opc=%b rd=%0d wbd=%h want all 0",
                     alu_op1, alu_op2, alu_imm, alu_opcode, wb_rd, wb_data);
        end
        compared++;
        if (instr_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready: got %b want 1", instr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_addi_chain();
        int n, en;
        send(32'h00500093);
        run_to_wb(n, en);
        compared++;
        if (n !== 4) begin
            mismatched++;
            $display("FAIL addi1_latency: got %0d want 4", n);
        end
        compared++;
        if (wb_rd !== 5'd1 || wb_data !== 32'd5) begin
            mismatched++;
            $display("FAIL addi1_wb: got rd=%0d data=%h want rd=1 data=00000005", wb_rd, wb_data);
        end
        send(32'hFFD00113);
        run_to_wb(n, en);
        compared++;
        if (n !== 4) begin
            mismatched++;
            $display("FAIL addi2_latency: got %0d want 4", n);
        end
        compared++;
        if (alu_i !== 1'b1 || alu_r !== 1'b0 || alu_imm !== 32'hFFFFFFFD || alu_op2 !== 32'd0) begin
            mismatched++;
            $display("FAIL addi2_operands: got i=%b r=%b imm=%h op2=%h want i=1 r=0 imm=fffffffd op2=0",
                     alu_i, alu_r, alu_imm, alu_op2);
        end
        dbg_addr = 5'd1;
        #1;
        compared++;
        if (dbg_data !== 32'd5) begin
            mismatched++;
            $display("FAIL x1: got %h want 00000005", dbg_data);
        end
        dbg_addr = 5'd2;
        #1;
        compared++;
        if (dbg_data !== 32'hFFFFFFFD) begin
            mismatched++;
            $display("FAIL x2: got %h want fffffffd", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        int n, en;
        compared++;
        if (instr_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_ready: got %b want 1", instr_ready);
        end
        send(32'h402081B3);
        run_to_wb(n, en);
        compared++;
        if (n !== 4) begin
            mismatched++;
            $display("FAIL sub_latency: got %0d want 4", n);
        end
        compared++;
        if (en !== 1) begin
            mismatched++;
            $display("FAIL sub_en_cycles: got %0d want 1", en);
        end
        compared++;
        if (alu_opcode !== 4'b0001 || alu_r !== 1'b1 || alu_i !== 1'b0) begin
            mismatched++;
            $display("FAIL sub_decode: got opc=%b r=%b i=%b want opc=0001 r=1 i=0", alu_opcode, alu_r, alu_i);
        end
        dbg_addr = 5'd3;
        #1;
        compared++;
        if (dbg_data !== 32'd8) begin
            mismatched++;
            $display("FAIL x3: got %h want 00000008", dbg_data);
        end
    endtask

    task automatic test_shift_cmp();
        int n, en;
        send(32'h40115213);
        // Offer another instruction while busy; it must not be consumed.
        instr_valid = 1'b1;
        instr       = 32'h00100413;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        run_to_wb(n, en);
        compared++;
        if (n !== 2) begin
            mismatched++;
            $display("FAIL srai_latency: got %0d remaining edges want 2", n);
        end
        compared++;
        if (alu_opcode !== 4'b1011) begin
            mismatched++;
            $display("FAIL srai_opcode: got %b want 1011", alu_opcode);
        end
        dbg_addr = 5'd4;
        #1;
        compared++;
        if (dbg_data !== 32'hFFFFFFFE) begin
            mismatched++;
            $display("FAIL x4: got %h want fffffffe", dbg_data);
        end
        send(32'h001132B3);
        run_to_wb(n, en);
        compared++;
        if (alu_opcode !== 4'b0110 || alu_op1 !== 32'hFFFFFFFD || alu_op2 !== 32'd5) begin
            mismatched++;
            $display("FAIL sltu_decode: got opc=%b op1=%h op2=%h want 0110 fffffffd 00000005",
                     alu_opcode, alu_op1, alu_op2);
        end
        compared++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'd0) begin
            mismatched++;
            $display("FAIL x5_wb: got v=%b rd=%0d data=%h want v=1 rd=5 data=0", wb_valid, wb_rd, wb_data);
        end
        dbg_addr = 5'd8;
        #1;
        compared++;
        if (dbg_data !== 32'd0) begin
            mismatched++;
            $display("FAIL x8_not_consumed: got %h want 00000000", dbg_data);
        end
    endtask

    task automatic test_illegal();
        int ill_cnt, en_cnt;
        logic [31:0] words [2];
        words[0] = 32'h0000006F;
        words[1] = 32'h40111193;
        for (int k = 0; k < 2; k++) begin
            send(words[k]);
            @(posedge clk);
            #1;
            compared++;
            if (illegal !== 1'b1 || instr_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL illegal_pulse%0d: got illegal=%b ready=%b want 1 1", k, illegal, instr_ready);
            end
            ill_cnt = 1;
            en_cnt  = 0;
            repeat (5) begin
                @(posedge clk);
                #1;
                if (illegal) ill_cnt++;
                if (alu_en || wb_valid) en_cnt++;
            end
            compared++;
            if (ill_cnt !== 1 || en_cnt !== 0) begin
                mismatched++;
                $display("FAIL illegal_quiet%0d: got pulses=%0d activity=%0d want 1 0", k, ill_cnt, en_cnt);
            end
            compared++;
            if (alu_opcode !== 4'b0110 || alu_op1 !== 32'hFFFFFFFD || alu_r !== 1'b1) begin
                mismatched++;
                $display("FAIL illegal_alu_hold%0d: got opc=%b op1=%h r=%b want 0110 fffffffd 1",
                         k, alu_opcode, alu_op1, alu_r);
            end
        end
        dbg_addr = 5'd3;
        #1;
        compared++;
        if (dbg_data !== 32'd8) begin
            mismatched++;
            $display("FAIL illegal_regs: got x3=%h want 00000008", dbg_data);
        end
    endtask

    task automatic test_x0_write();
        int n, en;
        send(32'h00700013);
        run_to_wb(n, en);
        compared++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 32'd7) begin
            mismatched++;
            $display("FAIL x0_wb: got v=%b rd=%0d data=%h want v=1 rd=0 data=7", wb_valid, wb_rd, wb_data);
        end
        dbg_addr = 5'd0;
        #1;
        compared++;
        if (dbg_data !== 32'd0) begin
            mismatched++;
            $display("FAIL x0_read: got %h want 0", dbg_data);
        end
    endtask

    task automatic test_reset_mid_op();
        int n, en, wb_cnt;
        send(32'h00900313);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        compared++;
        if (alu_en !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_exec_en: got %b want 1", alu_en);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({alu_en, alu_r, alu_i, wb_valid, illegal, alu_opcode, alu_op1, alu_op2, alu_imm, wb_rd, wb_data}
            !== 142'd0) begin
            mismatched++;
            $display("FAIL rst_mid_outputs: got en=%b r=%b i=%b opc=%b op1=%h imm=%h rd=%0d wbd=%h want all 0",
                     alu_en, alu_r, alu_i, alu_opcode, alu_op1, alu_imm, wb_rd, wb_data);
        end
        @(negedge clk);
        rst = 1'b0;
        wb_cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (wb_valid) wb_cnt++;
        end
        compared++;
        if (wb_cnt !== 0 || instr_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_no_wb: got wb=%0d ready=%b want 0 1", wb_cnt, instr_ready);
        end
        dbg_addr = 5'd6;
        #1;
        compared++;
        if (dbg_data !== 32'd0) begin
            mismatched++;
            $display("FAIL x6_after_rst: got %h want 0", dbg_data);
        end
        dbg_addr = 5'd1;
        #1;
        compared++;
        if (dbg_data !== 32'd0) begin
            mismatched++;
            $display("FAIL x1_after_rst: got %h want 0", dbg_data);
        end
        send(32'h12300393);
        run_to_wb(n, en);
        compared++;
        if (n !== 4 || wb_rd !== 5'd7 || wb_data !== 32'h123) begin
            mismatched++;
            $display("FAIL post_rst_addi: got n=%0d rd=%0d data=%h want 4 7 00000123", n, wb_rd, wb_data);
        end
        dbg_addr = 5'd7;
        #1;
        compared++;
        if (dbg_data !== 32'h123) begin
            mismatched++;
            $display("FAIL x7: got %h want 00000123", dbg_data);
        end
    endtask

    initial begin
        test_reset();
        test_addi_chain();
        test_back_to_back();
        test_shift_cmp();
        test_illegal();
        test_x0_write();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
